serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = ain - bin, LSB first, one bit per clock.
// A single full-subtractor cell walks the operand shift registers while the
// borrow flop carries between bit positions. The final borrow flags ain < bin.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] ain,
  input  logic [N-1:0] bin,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [N-1:0]   r_sh_q, r_sh_d;
  logic           br_q, br_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           borrow_q, borrow_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Full-subtractor cell on the current LSBs and the running borrow.
  logic           a_bit, b_bit, d_bit, br_next;
  logic [N-1:0]   r_next;

  assign a_bit   = a_sh_q[0];
  assign b_bit   = b_sh_q[0];
  assign d_bit   = a_bit ^ b_bit ^ br_q;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  assign r_next  = {d_bit, r_sh_q[N-1:1]};

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: accept in IDLE, shift N times, publish on the last shift.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_sh_d  = ain;
          b_sh_d  = bin;
          r_sh_d  = '0;
          br_d    = 1'b0;
          cnt_d   = CW'(N - 1);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[N-1:1]};
        b_sh_d = {1'b0, b_sh_q[N-1:1]};
        r_sh_d = r_next;
        br_d   = br_next;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Last bit: results become visible only here, never mid-operation.
          diff_d   = r_next;
          borrow_d = br_next;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N = 8). Expected results come
// from plain integer subtraction modulo 2^N and an unsigned compare.
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] ain;
  logic [N-1:0] bin;
  logic [N-1:0] diff;
  logic         borrow;
  logic         busy;
  logic         done;

  int checks;
  int fails;

  serial_subtractor #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ain    (ain),
    .bin    (bin),
    .diff   (diff),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_diff(input int a, input int b);
    int r;
    r = (a - b + (1 << N)) % (1 << N);
    return r[N-1:0];
  endfunction

  function automatic logic model_borrow(input int a, input int b);
    return (a < b);
  endfunction

  // Start one operation from IDLE and wait (bounded) for its done pulse.
  // edges = shift edges after the accepting edge (-1 on timeout).
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       output int edges, output bit busy_ok,
                       output bit held, output bit early_done);
    logic [N-1:0] d0;
    d0 = diff;
    busy_ok = 1'b1;
    held = 1'b1;
    early_done = 1'b0;
    ain = a;
    bin = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ain = N'($urandom);
    bin = N'($urandom);
    edges = 0;
    while (1) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (diff !== d0) held = 1'b0;
      if (done !== 1'b0) early_done = 1'b1;
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) break;
      if (edges > 4 * N) begin
        edges = -1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    ain = '0;
    bin = '0;
    #12;
    checks++; if (diff !== '0) begin fails++; $display("FAIL reset_diff: got %0h expected 0", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL reset_borrow: got %0b expected 0", borrow); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", done); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_directed;
    int ta[5] = '{100, 37, 0, 0, 255};
    int tb[5] = '{37, 100, 0, 1, 255};
    int edges;
    bit busy_ok, held, early;
    for (int i = 0; i < 5; i++) begin
      do_op(N'(ta[i]), N'(tb[i]), edges, busy_ok, held, early);
      checks++; if (edges !== N) begin fails++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, edges, N); end
      checks++; if (diff !== model_diff(ta[i], tb[i])) begin fails++; $display("FAIL dir_diff[%0d]: got %0h expected %0h", i, diff, model_diff(ta[i], tb[i])); end
      checks++; if (borrow !== model_borrow(ta[i], tb[i])) begin fails++; $display("FAIL dir_borrow[%0d]: got %0b expected %0b", i, borrow, model_borrow(ta[i], tb[i])); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL dir_busy_end[%0d]: got %0b expected 0", i, busy); end
      checks++; if (!busy_ok) begin fails++; $display("FAIL dir_busy_during[%0d]: got low expected high", i); end
      checks++; if (!held) begin fails++; $display("FAIL dir_diff_stable[%0d]: got changed expected held", i); end
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL dir_done_pulse[%0d]: got %0b expected 0", i, done); end
    end
  endtask

  task automatic test_random;
    int edges;
    bit busy_ok, held, early;
    int a, b;
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, (1 << N) - 1));
      b = int'($urandom_range(0, (1 << N) - 1));
      do_op(N'(a), N'(b), edges, busy_ok, held, early);
      checks++; if (edges !== N) begin fails++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, edges, N); end
      checks++; if (diff !== model_diff(a, b)) begin fails++; $display("FAIL rnd_diff[%0d] %0d-%0d: got %0h expected %0h", i, a, b, diff, model_diff(a, b)); end
      checks++; if (borrow !== model_borrow(a, b)) begin fails++; $display("FAIL rnd_borrow[%0d] %0d-%0d: got %0b expected %0b", i, a, b, borrow, model_borrow(a, b)); end
      repeat (int'($urandom_range(0, 2))) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_start_while_busy;
    int edges;
    int dones;
    ain = 8'd50;
    bin = 8'd20;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 0;
    dones = 0;
    while (edges <= 4 * N) begin
      if (edges >= 2 && edges < 5) begin
        start = 1'b1;
        ain = (edges == 2) ? 8'd1 : N'($urandom);
        bin = (edges == 2) ? 8'd2 : N'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) break;
    end
    start = 1'b0;
    checks++; if (edges !== N) begin fails++; $display("FAIL busy_start_latency: got %0d expected %0d", edges, N); end
    checks++; if (diff !== 8'd30) begin fails++; $display("FAIL busy_start_diff: got %0d expected 30", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL busy_start_borrow: got %0b expected 0", borrow); end
    repeat (N + 3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin fails++; $display("FAIL busy_start_extra_op: got %0d extra cycles expected 0", dones); end
  endtask

  task automatic test_back_to_back;
    int edges;
    bit busy_ok, held, early;
    do_op(8'd9, 8'd4, edges, busy_ok, held, early);
    checks++; if (diff !== 8'd5) begin fails++; $display("FAIL b2b_first_diff: got %0d expected 5", diff); end
    // Still in the done cycle: the next request is accepted on this edge.
    do_op(8'd4, 8'd9, edges, busy_ok, held, early);
    checks++; if (early) begin fails++; $display("FAIL b2b_done_drop: got high expected low after one cycle"); end
    checks++; if (!busy_ok) begin fails++; $display("FAIL b2b_busy: got low expected high during second op"); end
    checks++; if (!held) begin fails++; $display("FAIL b2b_diff_hold: got changed expected 5 held"); end
    checks++; if (edges !== N) begin fails++; $display("FAIL b2b_latency: got %0d expected %0d", edges, N); end
    checks++; if (diff !== 8'hFB) begin fails++; $display("FAIL b2b_diff: got %0h expected fb", diff); end
    checks++; if (borrow !== 1'b1) begin fails++; $display("FAIL b2b_borrow: got %0b expected 1", borrow); end
  endtask

  task automatic test_reset_mid_shift;
    int edges;
    int dones;
    bit busy_ok, held, early;
    ain = 8'd77;
    bin = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    checks++; if (diff !== '0) begin fails++; $display("FAIL mid_reset_diff: got %0h expected 0", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL mid_reset_borrow: got %0b expected 0", borrow); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %0b expected 0", busy); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    dones = 0;
    repeat (N + 3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin fails++; $display("FAIL mid_reset_no_done: got %0d active cycles expected 0", dones); end
    do_op(8'd200, 8'd55, edges, busy_ok, held, early);
    checks++; if (edges !== N) begin fails++; $display("FAIL post_reset_latency: got %0d expected %0d", edges, N); end
    checks++; if (diff !== 8'd145) begin fails++; $display("FAIL post_reset_diff: got %0d expected 145", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL post_reset_borrow: got %0b expected 0", borrow); end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
